hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Central stall/flush scheduler for the 5-stage RISC-V pipeline.
- Arbitrates three hazard sources: taken-branch redirects resolved in EX, load-use hazards detected in ID, and data-memory busy.
- Drives the PC mux select and target, plus the per-register stall, flush and freeze controls.
- Sits beside the IF/ID/EX pipeline registers and replaces ad-hoc per-stage reset wiring.

Parameters:
- WIDTH, 32, PC/target width.
- FLUSH_DEPTH, 1, number of consecutive cycles IF/ID is flushed after a redirect (legal values 1..3).

Ports:
- CLK  input  1  pipeline clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- BRANCH_IN  input  1  taken branch/jump resolved in EX this cycle.
- TARGET_IN  input  WIDTH  redirect target, valid when BRANCH_IN=1.
- LOAD_USE_IN  input  1  instruction in ID depends on a load in EX.
- MEM_BUSY_IN  input  1  data memory not ready; the pipeline must hold.
- PC_SEL_OUT  output  1  1 = PC loads PC_TARGET_OUT.
- PC_TARGET_OUT  output  WIDTH  redirect address.
- STALL_PC_OUT  output  1  hold PC.
- STALL_IFID_OUT  output  1  hold IF/ID register.
- FLUSH_IFID_OUT  output  1  clear IF/ID to NOP.
- FLUSH_IDEX_OUT  output  1  clear ID/EX to NOP (bubble).
- FREEZE_OUT  output  1  hold every pipeline register.
- STATE_OUT  output  2  current state, for debug.
- BRANCH_CNT_OUT  output  16  see Optional Feature.
- STALL_CNT_OUT  output  16  see Optional Feature.

Behaviour:
- Interface: one clock, CLK. RESET is asynchronous and active-high.
- Registered state: state (RUN=0, FREEZE=1, FLUSH=2), cnt (2 bits), pend (1 bit), pend_tgt (WIDTH bits).
- All outputs are combinational from the registered state and the inputs. While RESET=1, every output is forced to 0 and state=RUN, cnt=0, pend=0, pend_tgt=0.
- Priority, every cycle: MEM_BUSY_IN > redirect (BRANCH_IN or pend) > LOAD_USE_IN.
- RUN, MEM_BUSY_IN=1:
  - FREEZE_OUT=1; next state FREEZE.
  - If BRANCH_IN=1, capture pend=1 and pend_tgt=TARGET_IN.
- RUN, MEM_BUSY_IN=0, BRANCH_IN=1 (redirect):
  - Outputs: PC_SEL_OUT=1, PC_TARGET_OUT=TARGET_IN, FLUSH_IFID_OUT=1, FLUSH_IDEX_OUT=1.
  - LOAD_USE_IN is ignored this cycle.
  - If FLUSH_DEPTH>1, next state FLUSH with cnt=FLUSH_DEPTH-1; otherwise stay in RUN.
- RUN, MEM_BUSY_IN=0, BRANCH_IN=0, LOAD_USE_IN=1 (bubble):
  - STALL_PC_OUT=1, STALL_IFID_OUT=1, FLUSH_IDEX_OUT=1.
  - One cycle per asserted cycle; the upstream detector deasserts LOAD_USE_IN once the bubble is inserted.
- FREEZE:
  - While MEM_BUSY_IN=1: FREEZE_OUT=1.
  - A BRANCH_IN seen while pend=0 is captured. Once pend=1 it is not overwritten (the EX register is frozen, so the value is identical anyway).
- Leaving FREEZE (MEM_BUSY_IN=0), first matching case wins:
  - pend=1 (or BRANCH_IN=1): redirect using pend_tgt (TARGET_IN if pend=0), same outputs as the RUN redirect; clear pend; next state FLUSH or RUN per FLUSH_DEPTH.
  - else cnt!=0: next state FLUSH.
  - else: behave as RUN for this cycle, including the load-use case.
- FLUSH:
  - Outputs: FLUSH_IFID_OUT=1; cnt decrements; next state RUN when cnt reaches 0.
  - LOAD_USE_IN is ignored; it is wrong-path.
  - MEM_BUSY_IN=1: FREEZE_OUT=1, cnt held, next state FREEZE; flushing resumes afterwards.
  - A new BRANCH_IN cannot occur in FLUSH (EX holds a bubble). If it does occur, it is treated as a fresh redirect and cnt is reloaded.
- Simultaneous events:
  - BRANCH_IN with LOAD_USE_IN: redirect only, no stall.
  - MEM_BUSY_IN with BRANCH_IN: freeze; redirect deferred, never lost.
- Reset mid-FREEZE or mid-FLUSH: the pending redirect and cnt are discarded immediately.
- STATE_OUT = state.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - BRANCH_CNT_OUT increments on each cycle with PC_SEL_OUT=1.
  - STALL_CNT_OUT increments on each cycle with STALL_PC_OUT=1 or FREEZE_OUT=1.
  - Both are 16-bit, saturate at 0xFFFF and clear on RESET.
- Not defined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- RESET=1 mid-run -> all outputs 0 immediately (asynchronous); STATE_OUT=0 after release.
- BRANCH_IN=1, TARGET_IN=0x0000_0100, FLUSH_DEPTH=1 -> same cycle PC_SEL_OUT=1, PC_TARGET_OUT=0x100, FLUSH_IFID_OUT=FLUSH_IDEX_OUT=1; next cycle all controls 0.
- FLUSH_DEPTH=3, BRANCH_IN pulse -> FLUSH_IFID_OUT high for 3 consecutive cycles; STATE_OUT=2 for cycles 2-3.
- LOAD_USE_IN=1 for one cycle, no branch -> STALL_PC_OUT=STALL_IFID_OUT=FLUSH_IDEX_OUT=1 for exactly that cycle.
- MEM_BUSY_IN=1 for 4 cycles, BRANCH_IN=1 with TARGET_IN=0x200 in cycle 1 -> FREEZE_OUT=1 for 4 cycles, PC_SEL_OUT=0; cycle 5 PC_SEL_OUT=1 with PC_TARGET_OUT=0x200.
- BRANCH_IN and LOAD_USE_IN together -> redirect only, STALL_PC_OUT=0. With HAZARD_STATS_EN: BRANCH_CNT_OUT=1 and STALL_CNT_OUT unchanged.

Source files
------------

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - stall/flush/freeze scheduler for a 5-stage RISC-V pipeline
//
// Arbitrates three hazard sources, in priority order: data-memory busy,
// branch/jump redirect (new or deferred), and load-use hazard.
// Optional statistics counters are compiled in with HAZARD_STATS_EN.
//
// Ports:
//   CLK            pipeline clock, rising edge
//   RESET          asynchronous active-high reset
//   BRANCH_IN      taken branch/jump resolved in EX this cycle
//   TARGET_IN      redirect target, valid with BRANCH_IN
//   LOAD_USE_IN    ID instruction depends on a load in EX
//   MEM_BUSY_IN    data memory not ready, pipeline must hold
//   PC_SEL_OUT     1 = PC loads PC_TARGET_OUT
//   PC_TARGET_OUT  redirect address
//   STALL_PC_OUT   hold PC
//   STALL_IFID_OUT hold IF/ID
//   FLUSH_IFID_OUT clear IF/ID to NOP
//   FLUSH_IDEX_OUT clear ID/EX to NOP
//   FREEZE_OUT     hold every pipeline register
//   STATE_OUT      current state (RUN=0, FREEZE=1, FLUSH=2)
//   BRANCH_CNT_OUT redirect cycle count (0 unless HAZARD_STATS_EN)
//   STALL_CNT_OUT  stall/freeze cycle count (0 unless HAZARD_STATS_EN)

module hazard_sequencer #(
  parameter int WIDTH       = 32,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BRANCH_IN,
  input  logic [WIDTH-1:0] TARGET_IN,
  input  logic             LOAD_USE_IN,
  input  logic             MEM_BUSY_IN,
  output logic             PC_SEL_OUT,
  output logic [WIDTH-1:0] PC_TARGET_OUT,
  output logic             STALL_PC_OUT,
  output logic             STALL_IFID_OUT,
  output logic             FLUSH_IFID_OUT,
  output logic             FLUSH_IDEX_OUT,
  output logic             FREEZE_OUT,
  output logic [1:0]       STATE_OUT,
  output logic [15:0]      BRANCH_CNT_OUT,
  output logic [15:0]      STALL_CNT_OUT
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  // IF/ID flush cycles that remain after the redirect cycle itself
  localparam logic [1:0] RELOAD = 2'(FLUSH_DEPTH - 1);

  state_t           state, state_nxt;
  logic [1:0]       cnt, cnt_nxt;
  logic             pend, pend_nxt;
  logic [WIDTH-1:0] pend_tgt, pend_tgt_nxt;

  logic             pc_sel;
  logic [WIDTH-1:0] pc_target;
  logic             stall_pc, stall_ifid, flush_ifid, flush_idex, freeze;
  logic             do_redirect;
  logic [WIDTH-1:0] redirect_tgt;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pend_nxt     = pend;
    pend_tgt_nxt = pend_tgt;
    pc_sel       = 1'b0;
    pc_target    = '0;
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    freeze       = 1'b0;
    do_redirect  = 1'b0;
    redirect_tgt = TARGET_IN;

    case (state)
      ST_RUN: begin
        if (MEM_BUSY_IN) begin
          // Redirect is deferred across the freeze, never dropped
          freeze    = 1'b1;
          state_nxt = ST_FREEZE;
          if (BRANCH_IN) begin
            pend_nxt     = 1'b1;
            pend_tgt_nxt = TARGET_IN;
          end
        end else if (BRANCH_IN) begin
          do_redirect = 1'b1;
        end else if (LOAD_USE_IN) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end
      end

      ST_FREEZE: begin
        if (MEM_BUSY_IN) begin
          freeze = 1'b1;
          // EX is frozen, so a second capture would carry the same target
          if (BRANCH_IN && !pend) begin
            pend_nxt     = 1'b1;
            pend_tgt_nxt = TARGET_IN;
          end
        end else if (pend || BRANCH_IN) begin
          do_redirect  = 1'b1;
          redirect_tgt = pend ? pend_tgt : TARGET_IN;
        end else if (cnt != 2'd0) begin
          // Freeze interrupted a flush sequence; finish it
          state_nxt = ST_FLUSH;
        end else begin
          state_nxt = ST_RUN;
          if (LOAD_USE_IN) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        if (MEM_BUSY_IN) begin
          freeze    = 1'b1;
          state_nxt = ST_FREEZE;
          if (BRANCH_IN && !pend) begin
            pend_nxt     = 1'b1;
            pend_tgt_nxt = TARGET_IN;
          end
        end else if (BRANCH_IN) begin
          do_redirect = 1'b1;
        end else begin
          // LOAD_USE_IN is wrong-path here and deliberately ignored
          flush_ifid = 1'b1;
          if (cnt <= 2'd1) begin
            cnt_nxt   = 2'd0;
            state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt - 2'd1;
          end
        end
      end

      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = 2'd0;
      end
    endcase

    if (do_redirect) begin
      pc_sel     = 1'b1;
      pc_target  = redirect_tgt;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      pend_nxt   = 1'b0;
      if (FLUSH_DEPTH > 1) begin
        state_nxt = ST_FLUSH;
        cnt_nxt   = RELOAD;
      end else begin
        state_nxt = ST_RUN;
        cnt_nxt   = 2'd0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_RUN;
      cnt      <= 2'd0;
      pend     <= 1'b0;
      pend_tgt <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend     <= pend_nxt;
      pend_tgt <= pend_tgt_nxt;
    end
  end

  // Outputs are forced low for the whole time RESET is high, even though
  // the inputs may still be toggling.
  assign PC_SEL_OUT     = !RESET && pc_sel;
  assign PC_TARGET_OUT  = RESET ? '0 : pc_target;
  assign STALL_PC_OUT   = !RESET && stall_pc;
  assign STALL_IFID_OUT = !RESET && stall_ifid;
  assign FLUSH_IFID_OUT = !RESET && flush_ifid;
  assign FLUSH_IDEX_OUT = !RESET && flush_idex;
  assign FREEZE_OUT     = !RESET && freeze;
  assign STATE_OUT      = RESET ? 2'd0 : state;

`ifdef HAZARD_STATS_EN
  logic [15:0] branch_cnt, stall_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      branch_cnt <= 16'd0;
      stall_cnt  <= 16'd0;
    end else begin
      if (pc_sel && branch_cnt != 16'hFFFF)
        branch_cnt <= branch_cnt + 16'd1;
      if ((stall_pc || freeze) && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign BRANCH_CNT_OUT = branch_cnt;
  assign STALL_CNT_OUT  = stall_cnt;
`else
  assign BRANCH_CNT_OUT = 16'd0;
  assign STALL_CNT_OUT  = 16'd0;
`endif

endmodule
